// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback request types
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        reg_addr_t addr;
        xlen_t     data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - reusable round-robin arbiter with one-hot grant and index
module rr_arbiter #(
    parameter  int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    logic [W-1:0] ptr;
    int unsigned  cand;

    // Grant the first requester found scanning upward from ptr, wrapping at N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = W'(cand);
                gnt_any   = 1'b1;
            end
        end
    end

    // Move the pointer just past the winner; explicit wrap keeps non-power-of-2 N in range.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (gnt_any) begin
            if (gnt_idx == W'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gnt_idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - serializes writeback producers onto the register-file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int XLen      = XLEN,
    parameter  int NReg      = NREG,
    parameter  int NSrc      = 3,
    localparam int NRegWidth = $clog2(NReg),
    localparam int NSrcWidth = $clog2(NSrc)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NSrc-1:0]                src_valid_i,
    output logic [NSrc-1:0]                src_ready_o,
    input  logic [NSrc-1:0][NRegWidth-1:0] src_addr_i,
    input  logic [NSrc-1:0][XLen-1:0]      src_data_i,
    output logic [NRegWidth-1:0]           a3_o,
    output logic                           we3_o,
    output logic [XLen-1:0]                wd3_o,
    output logic                           busy_o
);

    logic [NSrc-1:0]      gnt;
    logic [NSrcWidth-1:0] gnt_idx;
    logic                 gnt_any;
    logic [NRegWidth-1:0] sel_addr;
    logic [XLen-1:0]      sel_data;
    logic                 wr_ok;

    rr_arbiter #(
        .N(NSrc)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (src_valid_i),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_any(gnt_any)
    );

    assign src_ready_o = gnt;

    // Route the winning producer's address and data; zero when nobody is granted.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NSrc; i++) begin
            if (gnt_any && (gnt_idx == NSrcWidth'(i))) begin
                sel_addr = src_addr_i[i];
                sel_data = src_data_i[i];
            end
        end
    end

    // Writes to x0 are accepted from the producer but never reach the register file.
    assign wr_ok = gnt_any && (sel_addr != '0);

    // Single output register; address and data are forced to zero whenever no write is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we3_o <= 1'b0;
            a3_o  <= '0;
            wd3_o <= '0;
        end else begin
            we3_o <= wr_ok;
            a3_o  <= wr_ok ? sel_addr : '0;
            wd3_o <= wr_ok ? sel_data : '0;
        end
    end

    assign busy_o = (|src_valid_i) | we3_o;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed checks against a behavioural model
module tb_regfile_wb_arbiter;

    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS-1:0][4:0]  src_addr;
    logic [NS-1:0][31:0] src_data;
    logic [4:0]        a3;
    logic              we3;
    logic [31:0]       wd3;
    logic              busy;

    regfile_wb_arbiter #(.XLen(32), .NReg(32), .NSrc(NS)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .src_valid_i(src_valid),
        .src_ready_o(src_ready),
        .src_addr_i (src_addr),
        .src_data_i (src_data),
        .a3_o       (a3),
        .we3_o      (we3),
        .wd3_o      (wd3),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // producer state
    logic        vld [NS];
    logic [4:0]  adr [NS];
    logic [31:0] dat [NS];

    // model state
    int          m_ptr;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    int          waitc [NS];
    int          last_gnt;
    logic [NS-1:0] samp_ready;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            src_valid[i] = vld[i];
            src_addr[i]  = adr[i];
            src_data[i]  = dat[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        e_we  = 1'b0;
        e_a3  = '0;
        e_wd  = '0;
        for (int i = 0; i < NS; i++) waitc[i] = 0;
    endtask

    // One clock: drive at negedge, check ready/busy mid-cycle, check outputs after posedge.
    task automatic step();
        int g;
        logic [NS-1:0] exp_ready;
        logic any_v;
        @(negedge clk);
        drive();
        #1;
        g = -1;
        any_v = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int c;
            c = (m_ptr + k) % NS;
            if (g < 0 && vld[c]) g = c;
            if (vld[k]) any_v = 1'b1;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        samp_ready = src_ready;
        chk("ready", 64'(src_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(any_v | e_we));
        if (g >= 0) begin
            chk("starve_bound", 64'(waitc[g] < NS), 64'd1);
            waitc[g] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            if (vld[i] && i != g) waitc[i]++;
        end
        last_gnt = g;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_ptr = (g + 1) % NS;
            e_we  = (adr[g] != 0);
            e_a3  = e_we ? adr[g] : 5'd0;
            e_wd  = e_we ? dat[g] : 32'd0;
        end else begin
            e_we = 1'b0;
            e_a3 = '0;
            e_wd = '0;
        end
        chk("we3", 64'(we3), 64'(e_we));
        chk("a3", 64'(a3), 64'(e_a3));
        chk("wd3", 64'(wd3), 64'(e_wd));
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            vld[i] = 1'b0;
            adr[i] = '0;
            dat[i] = '0;
        end
    endtask

    initial begin
        clear_all();
        model_reset();
        last_gnt = -1;
        samp_ready = '0;

        // reset with all producers requesting
        for (int i = 0; i < NS; i++) begin
            vld[i] = 1'b1;
            adr[i] = 5'(i + 1);
            dat[i] = $urandom;
        end
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        @(posedge clk);
        #2 rst_ni = 1'b1;

        // round robin: 6 grants with continuous re-assertion, then 3 draining
        for (int s = 0; s < 9; s++) begin
            step();
            chk("rr_grant", 64'(samp_ready), 64'(1 << (s % NS)));
            chk("rr_nogap", 64'(we3), 64'd1);
            if (last_gnt >= 0) begin
                if (s < 6) dat[last_gnt] = $urandom;
                else vld[last_gnt] = 1'b0;
            end
        end

        // single write from src1
        vld[1] = 1'b1; adr[1] = 5'd5; dat[1] = 32'hDEADBEEF;
        step();
        chk("single_ready", 64'(samp_ready), 64'b010);
        chk("single_we", 64'(we3), 64'd1);
        chk("single_a3", 64'(a3), 64'd5);
        chk("single_wd", 64'(wd3), 64'hDEADBEEF);
        vld[1] = 1'b0;
        step();
        chk("single_we_off", 64'(we3), 64'd0);

        // x0 drop from src0
        vld[0] = 1'b1; adr[0] = 5'd0; dat[0] = 32'h1234;
        step();
        chk("x0_ready", 64'(samp_ready), 64'b001);
        chk("x0_we", 64'(we3), 64'd0);
        chk("x0_wd", 64'(wd3), 64'd0);
        vld[0] = 1'b0;

        // move ptr to 2, then valids 101: grant 2 then 0
        vld[1] = 1'b1; adr[1] = 5'd9; dat[1] = $urandom;
        step();
        vld[1] = 1'b0;
        vld[0] = 1'b1; adr[0] = 5'd10; dat[0] = $urandom;
        vld[2] = 1'b1; adr[2] = 5'd11; dat[2] = $urandom;
        step();
        chk("wrap_first", 64'(samp_ready), 64'b100);
        dat[2] = $urandom;
        step();
        chk("wrap_second", 64'(samp_ready), 64'b001);
        vld[0] = 1'b0;
        step();
        vld[2] = 1'b0;

        // async reset while a write is on the port
        vld[0] = 1'b1; adr[0] = 5'd7; dat[0] = 32'hCAFE0007;
        step();
        chk("pre_rst_we", 64'(we3), 64'd1);
        vld[0] = 1'b1; adr[0] = 5'd12; dat[0] = $urandom;
        vld[1] = 1'b1; adr[1] = 5'd13; dat[1] = $urandom;
        #1 rst_ni = 1'b0;
        #1;
        chk("async_we", 64'(we3), 64'd0);
        chk("async_a3", 64'(a3), 64'd0);
        chk("async_wd", 64'(wd3), 64'd0);
        model_reset();
        drive();
        @(posedge clk);
        #2 rst_ni = 1'b1;
        step();
        chk("post_rst_grant", 64'(samp_ready), 64'b001);
        vld[0] = 1'b0;
        step();
        vld[1] = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    vld[i] = 1'b1;
                    adr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    dat[i] = $urandom;
                end
            end
            step();
            if (last_gnt >= 0) vld[last_gnt] = 1'b0;
        end
        for (int n = 0; n < 2 * NS; n++) begin
            step();
            if (last_gnt >= 0) vld[last_gnt] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end of the integer register file.
- Collects writeback results from NSrc producers (ALU, load unit, mul/div, ...) and serializes them onto the single register-file write port (address, write enable, write data).
- Round-robin arbitration with per-source valid/ready handshake.
- Registered output stage gives one cycle of latency; writes to x0 are dropped.

Parameters:
- XLen, 32, data width of a register.
- NReg, 32, number of architectural registers.
- NSrc, 3, number of writeback producers (legal range 2..8).
- NRegWidth, $clog2(NReg), localparam, register address width.
- NSrcWidth, $clog2(NSrc), localparam, round-robin pointer width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- src_valid_i  input  [NSrc]  producer i has a result.
- src_ready_o  output  [NSrc]  producer i accepted this cycle.
- src_addr_i  input  [NSrc][NRegWidth]  destination register of producer i.
- src_data_i  input  [NSrc][XLen]  result data of producer i.
- a3_o  output  NRegWidth  register-file write address.
- we3_o  output  1  register-file write enable.
- wd3_o  output  XLen  register-file write data.
- busy_o  output  1  any src_valid_i high, or we3_o high.

Behaviour:
- Reset state (asynchronous, rst_ni low): we3_o=0, a3_o=0, wd3_o=0, rr pointer=0.
- Reset mid-operation discards the registered write; no partial write is issued.
- Handshake: transfer on src_valid_i[i] & src_ready_o[i].
- Producer rules: once valid is raised, it holds valid, addr and data stable until accepted. Valid may not depend on ready.
- src_ready_o is combinational from src_valid_i and the pointer.
- src_ready_o is one-hot or zero, and is never high without the matching valid.
- Arbitration: grant the first valid source searching from index ptr upward, wrapping modulo NSrc.
- Pointer update: after a grant to i, ptr <= (i+1) mod NSrc. With no grant, ptr holds.
- Wrap: i=NSrc-1 sets ptr to 0. Non-power-of-2 NSrc must wrap correctly (e.g. NSrc=3: 2 goes to 0, never 3).
- The write port never stalls, so some valid source is granted every cycle any valid is high.
- Output register, latency 1:
  - A transfer in cycle N with addr != 0 gives we3_o=1, a3_o=addr, wd3_o=data in cycle N+1, for exactly one cycle.
  - A transfer in cycle N with addr == 0 is accepted (ready=1), but we3_o=0 in cycle N+1.
  - Whenever we3_o=0, a3_o=0 and wd3_o=0.
- Back-to-back transfers every cycle are supported, giving 1 write/cycle throughput.
- Simultaneous valids: only one is granted. The others stay pending and are served in round-robin order.
- Starvation bound: a pending source is granted within NSrc cycles.
- Ordering of writes to the same register from different producers is the producers' responsibility. The block guarantees only that a later-accepted write lands later.
- busy_o is combinational.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN, NREG, REG_ADDR_W constants.
  - typedef reg_addr_t, xlen_t.
  - typedef wb_req_t (addr, data).
- One natural sub-module, rr_arbiter: parameter N; inputs req[N] and clk/rst. Outputs gnt[N] one-hot and gnt_idx; internal pointer. It is reusable for other arbiters.
- The top level adds the data mux, x0 filtering, output register and busy_o.

Test Plan:
- Reset: hold rst_ni=0 with src_valid_i=3'b111 -> src_ready_o is ignored-safe, we3_o=0, a3_o=0, wd3_o=0. Release; first grant goes to src 0 (ptr=0).
- Single write: src1 valid, addr=5, data=32'hDEADBEEF in cycle N -> src_ready_o=3'b010 in N; we3_o=1, a3_o=5, wd3_o=32'hDEADBEEF in N+1; we3_o=0 in N+2.
- x0 drop: src0 valid, addr=0, data=32'h1234 -> ready=1; next cycle we3_o=0, a3_o=0, wd3_o=0.
- Round-robin: all three valid continuously with distinct addrs 1/2/3 -> grants 0,1,2,0,1,2. Writes appear one cycle later in the same order, no gaps.
- Wrap/fairness: ptr=2, valids=3'b101 -> grant 2, then 0. Src 0 held valid while src2 re-asserts -> src 0 served within 3 cycles.
- Async reset mid-stream: assert rst_ni low while we3_o=1 -> we3_o drops immediately with no clock. After release, ptr=0, and a held src0 request is granted first.
